// File: rtl/mux_arbiter_pkg.sv
// mux_arb_pkg: shared definitions for mux_arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, SETTLE, GRANT, RELEASE)
//   MUX_ENB_*   : polarity of the shared mux tree's active-low enable
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    GRANT   = 2'b10,
    RELEASE = 2'b11
  } arb_state_e;

  localparam logic MUX_ENB_ON  = 1'b0;
  localparam logic MUX_ENB_OFF = 1'b1;

endpackage

// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: request/grant and mux-control bundle of mux_arbiter.
//   iReq  [N_REQ] : per-requester request, held for the whole use
//   oGnt  [N_REQ] : one-hot grant
//   oSel  [SEL_W] : mux select (index of the owner)
//   oEnb          : mux enable, active-low
//   oBusy         : arbiter not idle
// master = requester side, slave = arbiter side.
interface mux_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SEL_W = 2
);

  logic [N_REQ-1:0] iReq;
  logic [N_REQ-1:0] oGnt;
  logic [SEL_W-1:0] oSel;
  logic             oEnb;
  logic             oBusy;

  modport master (
    output iReq,
    input  oGnt,
    input  oSel,
    input  oEnb,
    input  oBusy
  );

  modport slave (
    input  iReq,
    output oGnt,
    output oSel,
    output oEnb,
    output oBusy
  );

endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_req   [N_REQ] : request vector
//   i_ptr   [SEL_W] : highest-priority index this round
//   o_idx_c [SEL_W] : first requesting index at or above i_ptr, wrapping
//   o_vld_c         : any request present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_idx_c,
  output logic             o_vld_c
);

  logic             w_hit_hi;
  logic             w_hit_lo;
  logic [SEL_W-1:0] w_idx_hi;
  logic [SEL_W-1:0] w_idx_lo;

  // Lowest request at/above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (i_req[j] && !w_hit_lo) begin
        w_hit_lo = 1'b1;
        w_idx_lo = SEL_W'(j);
      end
      if (i_req[j] && !w_hit_hi && (j >= 32'(i_ptr))) begin
        w_hit_hi = 1'b1;
        w_idx_hi = SEL_W'(j);
      end
    end
  end

  assign o_vld_c = w_hit_lo;
  assign o_idx_c = w_hit_hi ? w_idx_hi : w_idx_lo;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner of a shared 2:1 mux tree. Every change of
// oSel is followed by SETTLE_CYC cycles with the mux disabled so that the
// tree's propagation delay never glitches a live grant.
//   iClk          : clock, rising edge
//   iClr          : asynchronous reset, active-low
//   bus (slave)   : iReq in; oGnt, oSel, oEnb (active-low), oBusy out, all registered
// Parameters: N_REQ (2..8), SEL_W (2**SEL_W >= N_REQ), SETTLE_CYC (>=1),
//             MAX_HOLD (>=2, only present with MUX_ARB_TIMEOUT_EN).
// Macro MUX_ARB_TIMEOUT_EN: preempt a grant after MAX_HOLD cycles when
// another requester is waiting. Undefined: a grant lasts until its iReq drops.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned SETTLE_CYC = 1
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  parameter int unsigned MAX_HOLD   = 16
`endif
) (
  input logic          iClk,
  input logic          iClr,
  mux_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
`endif

  arb_state_e       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic             r_enb;
  logic             r_busy;

  arb_state_e       w_state_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic             w_enb_nxt;

  logic [N_REQ-1:0] w_sel_oh;
  logic             w_own_req;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_pick_vld;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_other_req;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .i_req   (bus.iReq),
    .i_ptr   (r_ptr),
    .o_idx_c (w_pick_idx),
    .o_vld_c (w_pick_vld)
  );

  // Ownership is tracked through the registered select, never through iReq directly.
  assign w_sel_oh  = N_REQ'(1) << r_sel;
  assign w_own_req = |(bus.iReq & w_sel_oh);
`ifdef MUX_ARB_TIMEOUT_EN
  assign w_other_req = |(bus.iReq & ~w_sel_oh);
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = '0;
    w_enb_nxt   = MUX_ENB_OFF;
`ifdef MUX_ARB_TIMEOUT_EN
    w_hold_nxt  = r_hold;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_sel_nxt   = w_pick_idx;
          w_cnt_nxt   = CNT_W'(SETTLE_CYC);
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // An owner that gives up before the mux settles is dropped without a grant.
        if (!w_own_req) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_sel_oh;
          w_enb_nxt   = MUX_ENB_ON;
`ifdef MUX_ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      GRANT: begin
        if (!w_own_req) begin
          w_state_nxt = RELEASE;
`ifdef MUX_ARB_TIMEOUT_EN
        end else if ((r_hold == HOLD_W'(MAX_HOLD - 1)) && w_other_req) begin
          w_state_nxt = RELEASE;
`endif
        end else begin
          w_gnt_nxt = w_sel_oh;
          w_enb_nxt = MUX_ENB_ON;
`ifdef MUX_ARB_TIMEOUT_EN
          if (r_hold != HOLD_W'(MAX_HOLD)) begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
`endif
        end
      end
      RELEASE: begin
        w_ptr_nxt   = (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer, counters and output registers.
  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_enb   <= MUX_ENB_OFF;
      r_busy  <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_enb   <= w_enb_nxt;
      r_busy  <= (w_state_nxt != IDLE);
`ifdef MUX_ARB_TIMEOUT_EN
      r_hold  <= w_hold_nxt;
`endif
    end
  end

  assign bus.oGnt  = r_gnt;
  assign bus.oSel  = r_sel;
  assign bus.oEnb  = r_enb;
  assign bus.oBusy = r_busy;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: self-checking bench for mux_arbiter.
// Main instance uses SETTLE_CYC=1; a second instance uses SETTLE_CYC=3.
// Expected grant owners are queued as requests are driven and popped when a
// grant appears. Timeout expectations follow MUX_ARB_TIMEOUT_EN.
module tb_mux_arbiter;

  localparam int unsigned N_REQ      = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned GRANT_WAIT = 20;
  localparam int unsigned HOLD_LIM   = 24;

  logic clk = 1'b0;
  logic clr;
  logic clr3;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned sb_q[$];

  always #5 clk = ~clk;

  mux_arbiter_if #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_if ();
  mux_arbiter_if #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_if3 ();

  mux_arbiter #(
    .N_REQ      (N_REQ),
    .SEL_W      (SEL_W),
    .SETTLE_CYC (1)
  ) dut (
    .iClk (clk),
    .iClr (clr),
    .bus  (u_if)
  );

  mux_arbiter #(
    .N_REQ      (N_REQ),
    .SEL_W      (SEL_W),
    .SETTLE_CYC (3)
  ) dut3 (
    .iClk (clk),
    .iClr (clr3),
    .bus  (u_if3)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] v);
    @(negedge clk);
    u_if.iReq = v;
  endtask

  task automatic drive_req3(input logic [3:0] v);
    @(negedge clk);
    u_if3.iReq = v;
  endtask

  // Wait for the next grant on the main instance and score its owner.
  task automatic await_grant(input string tag, output int unsigned gap);
    int unsigned own;
    logic        found;
    logic [31:0] exp_own;
    gap   = 0;
    found = 1'b0;
    own   = 0;
    for (int c = 0; c < GRANT_WAIT; c++) begin
      tick();
      if (u_if.oGnt != '0) begin
        found = 1'b1;
        break;
      end
      if (u_if.oEnb) gap++;
    end
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (u_if.oGnt[k]) own = k;
      end
      exp_own = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      check_eq({tag, "_owner"}, own, exp_own);
      check_eq({tag, "_onehot"}, 32'($onehot(u_if.oGnt)), 32'd1);
      check_eq({tag, "_sel"}, 32'(u_if.oSel), own);
      check_eq({tag, "_enb"}, 32'(u_if.oEnb), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned gap;
    int unsigned cnt;
    logic [3:0]  oh;

    clr        = 1'b0;
    clr3       = 1'b0;
    u_if.iReq  = 4'b1111;
    u_if3.iReq = 4'b0000;
    repeat (2) tick();

    // Reset values with every request asserted
    check_eq("rst_gnt",  u_if.oGnt,  32'd0);
    check_eq("rst_sel",  u_if.oSel,  32'd0);
    check_eq("rst_enb",  u_if.oEnb,  32'd1);
    check_eq("rst_busy", u_if.oBusy, 32'd0);

    @(negedge clk);
    clr  = 1'b1;
    clr3 = 1'b1;
    tick();
    check_eq("e0_sel",  u_if.oSel,  32'd0);
    check_eq("e0_busy", u_if.oBusy, 32'd1);
    check_eq("e0_gnt",  u_if.oGnt,  32'd0);
    check_eq("e0_enb",  u_if.oEnb,  32'd1);
    tick();
    check_eq("e1_gnt", u_if.oGnt, 32'h1);
    check_eq("e1_enb", u_if.oEnb, 32'd0);
    drive_req(4'b0000);
    tick();
    check_eq("rel_gnt",  u_if.oGnt,  32'd0);
    check_eq("rel_enb",  u_if.oEnb,  32'd1);
    check_eq("rel_busy", u_if.oBusy, 32'd1);
    tick();
    check_eq("idle_busy", u_if.oBusy, 32'd0);

    // Round-robin between req1 and req3, each owner drops for one cycle
    sb_q.push_back(1);
    sb_q.push_back(3);
    sb_q.push_back(1);
    sb_q.push_back(3);
    drive_req(4'b1010);
    for (int g = 0; g < 4; g++) begin
      await_grant("rr", gap);
      if (g != 0) check_eq("rr_gap", gap + 1, 32'd3);
      oh = u_if.oGnt;
      repeat (2) begin
        tick();
        check_eq("rr_hold", u_if.oGnt, 32'(oh));
      end
      drive_req((g == 3) ? 4'b0000 : (4'b1010 & ~oh));
      tick();
      check_eq("rr_rel_gnt", u_if.oGnt, 32'd0);
      check_eq("rr_rel_enb", u_if.oEnb, 32'd1);
      if (g != 3) drive_req(4'b1010);
    end
    tick();
    check_eq("rr_idle", u_if.oBusy, 32'd0);

    // Wrap-around: after req2 releases, pointer 3 must wrap to req0
    sb_q.push_back(2);
    drive_req(4'b0100);
    await_grant("wrap_a", gap);
    drive_req(4'b0000);
    tick();
    check_eq("wrap_rel", u_if.oGnt, 32'd0);
    sb_q.push_back(0);
    drive_req(4'b0101);
    await_grant("wrap", gap);
    check_eq("wrap_gap", gap + 1, 32'd3);
    drive_req(4'b0000);
    tick();
    tick();

    // Asynchronous reset in the middle of a req2 grant
    sb_q.push_back(2);
    drive_req(4'b0100);
    await_grant("amid", gap);
    #2;
    clr = 1'b0;
    #1;
    check_eq("arst_gnt",  u_if.oGnt,  32'd0);
    check_eq("arst_enb",  u_if.oEnb,  32'd1);
    check_eq("arst_busy", u_if.oBusy, 32'd0);
    check_eq("arst_sel",  u_if.oSel,  32'd0);
    drive_req(4'b0000);
    tick();
    check_eq("arst_hold_gnt", u_if.oGnt, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    sb_q.push_back(0);
    drive_req(4'b1111);
    await_grant("post_rst", gap);
    drive_req(4'b0000);
    tick();
    tick();

    // Long grant of req0 with req1 arriving at grant cycle 5
    sb_q.push_back(0);
    drive_req(4'b0001);
    await_grant("hold_a", gap);
    cnt = 1;
    while (cnt < HOLD_LIM) begin
      if (cnt == 5) drive_req(4'b0011);
      tick();
      if (u_if.oGnt != 4'b0001) break;
      cnt++;
    end
`ifdef MUX_ARB_TIMEOUT_EN
    check_eq("hold_preempt_len", cnt, 32'd16);
    check_eq("hold_preempt_gnt", u_if.oGnt, 32'd0);
    check_eq("hold_preempt_enb", u_if.oEnb, 32'd1);
`else
    check_eq("hold_keep_len", cnt, HOLD_LIM);
    check_eq("hold_keep_gnt", u_if.oGnt, 32'h1);
    drive_req(4'b0010);
    tick();
    check_eq("hold_rel_gnt", u_if.oGnt, 32'd0);
`endif
    sb_q.push_back(1);
    await_grant("hold_b", gap);
    check_eq("hold_gap", gap + 1, 32'd3);

    // req0 re-arbitrates and, alone, keeps its grant beyond MAX_HOLD
    sb_q.push_back(0);
    drive_req(4'b0001);
    tick();
    check_eq("hold_b_rel", u_if.oGnt, 32'd0);
    await_grant("solo", gap);
    cnt = 1;
    while (cnt < HOLD_LIM) begin
      tick();
      if (u_if.oGnt != 4'b0001) break;
      cnt++;
    end
    check_eq("solo_len", cnt, HOLD_LIM);
    drive_req(4'b0000);
    tick();
    tick();
    check_eq("solo_idle", u_if.oBusy, 32'd0);

    // SETTLE_CYC=3 instance: latency, then abort during settle
    drive_req3(4'b0010);
    tick();
    check_eq("s3_sel",  u_if3.oSel,  32'd1);
    check_eq("s3_busy", u_if3.oBusy, 32'd1);
    tick();
    tick();
    check_eq("s3_gnt_early", u_if3.oGnt, 32'd0);
    check_eq("s3_enb_early", u_if3.oEnb, 32'd1);
    tick();
    check_eq("s3_gnt", u_if3.oGnt, 32'h2);
    check_eq("s3_enb", u_if3.oEnb, 32'd0);
    drive_req3(4'b0000);
    tick();
    check_eq("s3_rel", u_if3.oGnt, 32'd0);
    tick();
    check_eq("s3_idle", u_if3.oBusy, 32'd0);

    drive_req3(4'b0100);
    tick();
    check_eq("ab_sel",  u_if3.oSel,  32'd2);
    check_eq("ab_busy", u_if3.oBusy, 32'd1);
    drive_req3(4'b0000);
    tick();
    check_eq("ab_busy_off", u_if3.oBusy, 32'd0);
    check_eq("ab_enb",      u_if3.oEnb,  32'd1);
    repeat (3) begin
      tick();
      check_eq("ab_no_gnt", u_if3.oGnt, 32'd0);
    end
    drive_req3(4'b0101);
    tick();
    check_eq("ab_ptr_kept", u_if3.oSel, 32'd2);
    tick();
    tick();
    tick();
    check_eq("ab_regrant", u_if3.oGnt, 32'h4);
    drive_req3(4'b0000);
    tick();
    tick();

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares one 2:1 `mux` cell tree between up to `N_REQ` requesters, driving the tree's select and active-low enable. Sequences every ownership change through a disabled settle window, so the `mux` propagation delay (up to 27 ns) never produces a glitching output while a grant is live. Sits between requester logic and the shared `mux` datapath, clocked alongside the `ffd` register stages.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `SEL_W`, 2, select width; must satisfy 2^`SEL_W` ≥ `N_REQ`
- `SETTLE_CYC`, 1, cycles the mux is held disabled after `oSel` changes (≥1)
- `MAX_HOLD`, 16, grant cycle limit; only used with `MUX_ARB_TIMEOUT_EN` (≥2)

Ports:
- `iClk`  in  1  clock, rising edge
- `iClr`  in  1  reset, asynchronous, active-low
- `iReq`  in  `N_REQ`  per-requester request; held high for the whole use
- `oGnt`  out  `N_REQ`  one-hot grant, registered
- `oSel`  out  `SEL_W`  mux select (index of chosen requester), registered
- `oEnb`  out  1  mux enable, active-low (0 = mux passes data), registered
- `oBusy`  out  1  high whenever state ≠ IDLE

## Operation
- Reset values: `oGnt`=0, `oSel`=0, `oEnb`=1, `oBusy`=0, round-robin pointer `ptr`=0, state IDLE.
- IDLE: `oEnb`=1, `oGnt`=0. If any `iReq` is high, pick the first high bit scanning upward from `ptr` with wrap-around. Load `oSel` with its index, load the settle counter with `SETTLE_CYC`, and go to SETTLE.
- SETTLE: `oEnb`=1, `oGnt`=0.
  - Counter decrements each edge; at an edge where it equals 1, go to GRANT.
  - If `iReq[oSel]` drops during SETTLE: return to IDLE with `ptr` unchanged and no grant issued.
- GRANT: `oEnb`=0, `oGnt`=one-hot(`oSel`). Stay while `iReq[oSel]`=1. When `iReq[oSel]`=0 is sampled, go to RELEASE.
- RELEASE: `oEnb`=1, `oGnt`=0 for exactly one cycle. `ptr` ← (`oSel`+1) mod `N_REQ`, then go to IDLE.
- Other requesters' `iReq` changes never disturb an active grant.
- `oSel` holds its value in IDLE and RELEASE.
- Reset asserted in any state immediately forces all reset values, with no RELEASE cycle.

## Timing
- Request sampled high at edge E0 in IDLE:
  - `oSel` valid and `oBusy`=1 after E0.
  - `oGnt`/`oEnb`=0 after E0+`SETTLE_CYC`.
  - Default latency: grant after E1.
- Release: `iReq` low sampled at edge Er → `oGnt`=0 and `oEnb`=1 after Er, IDLE after Er+1, next arbitration at Er+2.
- Minimum back-to-back handover gap with `oEnb`=1: 2+`SETTLE_CYC` cycles.
- All outputs change only on `iClk` rising edge or `iClr` falling edge.
- Combinational paths from `iReq` to any output are forbidden.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - A hold counter of width clog2(`MAX_HOLD`+1) clears on GRANT entry and increments each GRANT cycle, saturating.
  - When it reaches `MAX_HOLD`−1 and any other `iReq` bit is high, go to RELEASE even though `iReq[oSel]`=1. The grant therefore lasts exactly `MAX_HOLD` cycles.
  - With no other request pending, the grant continues.
  - A preempted requester still holding `iReq` re-arbitrates normally.
- Undefined: no hold counter; a grant lasts until its `iReq` drops.

## Structure
- Package `mux_arb_pkg`:
  - state encoding: IDLE=2'b00, SETTLE=2'b01, GRANT=2'b10, RELEASE=2'b11
  - `MUX_ENB_ON`=1'b0, `MUX_ENB_OFF`=1'b1
- Sub-module `rr_pick`: combinational round-robin picker with inputs `iReq` and `ptr`, outputs index and valid.
- `mux_arbiter` holds the FSM, counters, `ptr` and the output registers.

## Test plan
- Reset: `iClr`=0 with `iReq`=4'b1111 → `oGnt`=0, `oSel`=0, `oEnb`=1, `oBusy`=0. Release reset → grant to req0 after 2 edges.
- Round-robin: `iReq`=4'b1010 held, each owner drops for one cycle after 3 granted cycles → grant order 1,3,1,3 with a 3-cycle `oEnb`=1 gap between grants.
- Wrap-around: `ptr`=3 (req2 just released), `iReq`=4'b0101 → `oSel`=0 granted, not 2.
- Abort in settle: `SETTLE_CYC`=3, req2 drops one edge after selection → back to IDLE, no `oGnt` pulse, `ptr` unchanged.
- Reset mid-grant: `iClr` pulled low while `oGnt`=4'b0100 → `oGnt`=0 and `oEnb`=1 immediately, asynchronously.
- Timeout (`MUX_ARB_TIMEOUT_EN`, `MAX_HOLD`=16): req0 held, req1 raised at grant cycle 5 → req0 grant lasts exactly 16 cycles, then req1 granted. Repeat with only req0 → grant held past 16 cycles.
